// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
//   Control wrapper around the UART receive processor. It owns the active
//   frame configuration, swaps in a pending configuration only while the
//   line is idle, watches the line for start bits and times out frames the
//   processor never delivered, and buffers delivered frames in a small
//   show-ahead FIFO read through a valid/ready handshake.
//
// Ports
//   clk_16bd             16x baud clock (only clock)
//   rst                  synchronous active-high reset
//   rx                   serial line, asynchronous, monitored only
//   cfg_wr / cfg_*       configuration write strobe and requested fields
//   cfg_pending          a legal write is waiting to be applied
//   cfg_err              1-cycle pulse after a rejected write
//   frame_length, parity, parity_type, stop_bits
//                        active configuration driven to the processor
//   frame / frame_valid  received frame from the processor
//   rd_data / rd_valid / rd_ready
//                        FIFO head and read handshake
//   fifo_count           frames currently held
//   overflow / ovf_clr   sticky lost-frame flag and its clear
//   drop_cnt             saturating count of timed-out frames
// ---------------------------------------------------------------------------
module uart_rx_ctrl #(
    parameter int         DEPTH            = 4,
    parameter logic [3:0] DEF_FRAME_LENGTH = 4'd8,
    parameter logic       DEF_PARITY       = 1'b0,
    parameter logic       DEF_PARITY_TYPE  = 1'b0,
    parameter logic       DEF_STOP_BITS    = 1'b0
) (
    input  logic                     clk_16bd,
    input  logic                     rst,
    input  logic                     rx,
    input  logic                     cfg_wr,
    input  logic [3:0]               cfg_frame_length,
    input  logic                     cfg_parity,
    input  logic                     cfg_parity_type,
    input  logic                     cfg_stop_bits,
    output logic                     cfg_pending,
    output logic                     cfg_err,
    output logic [3:0]               frame_length,
    output logic                     parity,
    output logic                     parity_type,
    output logic                     stop_bits,
    input  logic [8:0]               frame,
    input  logic                     frame_valid,
    output logic [8:0]               rd_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    input  logic                     ovf_clr,
    output logic [7:0]               drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    // line monitor
    logic rx_s1_q, rx_s2_q, rx_s3_q;
    logic fv_q;
    logic fall, fv_rise;

    // control state
    state_t     state_q;
    logic [7:0] timer_q;
    logic [7:0] drop_cnt_q;
    logic [3:0] len_q, pend_len_q;
    logic       par_q, pend_par_q;
    logic       ptype_q, pend_ptype_q;
    logic       stop_q, pend_stop_q;
    logic       pend_q;
    logic       cfg_err_q;

    // FIFO
    logic [8:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic       cfg_legal, apply;
    logic [7:0] bits_sum, timer_load;
    logic [8:0] mask, push_data;
    logic       full, pop, push, ovf_set;

    assign fall    = rx_s3_q & ~rx_s2_q;
    assign fv_rise = frame_valid & ~fv_q;

    assign cfg_legal = (cfg_frame_length >= 4'd5) && (cfg_frame_length <= 4'd9);
    // A pending config only lands on an idle cycle that is not starting a frame.
    assign apply     = (state_q == IDLE) && !fall && pend_q;

    // start + data + parity + stop(s), plus one extra bit time of slack
    assign bits_sum   = 8'({4'd0, len_q}) + 8'({7'd0, par_q}) + 8'({7'd0, stop_q}) + 8'd3;
    assign timer_load = bits_sum << 4;

    // ~(all-ones << len) keeps exactly len low bits, including len = 9
    assign mask      = ~(9'h1FF << len_q);
    assign push_data = frame & mask;

    always_ff @(posedge clk_16bd) begin
        if (rst) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
            fv_q    <= 1'b0;
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
            fv_q    <= frame_valid;
        end
    end

    // Frame tracker plus configuration registers.
    always_ff @(posedge clk_16bd) begin
        if (rst) begin
            state_q      <= IDLE;
            timer_q      <= 8'd0;
            drop_cnt_q   <= 8'd0;
            len_q        <= DEF_FRAME_LENGTH;
            par_q        <= DEF_PARITY;
            ptype_q      <= DEF_PARITY_TYPE;
            stop_q       <= DEF_STOP_BITS;
            pend_len_q   <= DEF_FRAME_LENGTH;
            pend_par_q   <= DEF_PARITY;
            pend_ptype_q <= DEF_PARITY_TYPE;
            pend_stop_q  <= DEF_STOP_BITS;
            pend_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            cfg_err_q <= cfg_wr & ~cfg_legal;

            case (state_q)
                IDLE: begin
                    if (fall) begin
                        state_q <= BUSY;
                        timer_q <= timer_load;
                    end else if (pend_q) begin
                        len_q   <= pend_len_q;
                        par_q   <= pend_par_q;
                        ptype_q <= pend_ptype_q;
                        stop_q  <= pend_stop_q;
                    end
                end
                BUSY: begin
                    if (fv_rise) begin
                        state_q <= IDLE;
                    end else if (timer_q == 8'd0) begin
                        state_q <= IDLE;
                        if (drop_cnt_q != 8'hFF)
                            drop_cnt_q <= drop_cnt_q + 8'd1;
                    end else begin
                        timer_q <= timer_q - 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // A write landing on an apply cycle stays pending for a later cycle.
            if (cfg_wr && cfg_legal) begin
                pend_len_q   <= cfg_frame_length;
                pend_par_q   <= cfg_parity;
                pend_ptype_q <= cfg_parity_type;
                pend_stop_q  <= cfg_stop_bits;
                pend_q       <= 1'b1;
            end else if (apply) begin
                pend_q <= 1'b0;
            end
        end
    end

    // FIFO next state
    always_comb begin
        full    = (count_q == CW'(DEPTH));
        pop     = (count_q != '0) && rd_ready;
        // a pop in the same cycle frees the slot a full FIFO needs
        push    = fv_rise && (!full || pop);
        ovf_set = fv_rise && full && !pop;

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;

        ovf_d = ovf_q;
        if (ovf_set)
            ovf_d = 1'b1;
        else if (ovf_clr)
            ovf_d = 1'b0;
    end

    always_ff @(posedge clk_16bd) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk_16bd) begin
        if (push)
            mem_q[wr_ptr_q] <= push_data;
    end

    assign cfg_pending  = pend_q;
    assign cfg_err      = cfg_err_q;
    assign frame_length = len_q;
    assign parity       = par_q;
    assign parity_type  = ptype_q;
    assign stop_bits    = stop_q;
    assign rd_data      = mem_q[rd_ptr_q];
    assign rd_valid     = (count_q != '0);
    assign fifo_count   = count_q;
    assign overflow     = ovf_q;
    assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ctrl
//   Directed scenarios followed by a random phase. A behavioural model (config
//   values, a queue for the FIFO, arithmetic timeout) is stepped once per
//   clock and every observable output is compared after each edge.
// ---------------------------------------------------------------------------
module tb_uart_rx_ctrl;

    localparam int DEPTH = 4;

    logic                   clk_16bd = 1'b0;
    logic                   rst = 1'b1;
    logic                   rx = 1'b1;
    logic                   cfg_wr = 1'b0;
    logic [3:0]             cfg_frame_length = 4'd8;
    logic                   cfg_parity = 1'b0;
    logic                   cfg_parity_type = 1'b0;
    logic                   cfg_stop_bits = 1'b0;
    logic                   cfg_pending, cfg_err;
    logic [3:0]             frame_length;
    logic                   parity, parity_type, stop_bits;
    logic [8:0]             frame = 9'd0;
    logic                   frame_valid = 1'b0;
    logic [8:0]             rd_data;
    logic                   rd_valid;
    logic                   rd_ready = 1'b0;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   overflow;
    logic                   ovf_clr = 1'b0;
    logic [7:0]             drop_cnt;

    int vectors = 0;
    int miscompares = 0;

    uart_rx_ctrl #(.DEPTH(DEPTH)) dut (
        .clk_16bd(clk_16bd), .rst(rst), .rx(rx),
        .cfg_wr(cfg_wr), .cfg_frame_length(cfg_frame_length),
        .cfg_parity(cfg_parity), .cfg_parity_type(cfg_parity_type),
        .cfg_stop_bits(cfg_stop_bits),
        .cfg_pending(cfg_pending), .cfg_err(cfg_err),
        .frame_length(frame_length), .parity(parity),
        .parity_type(parity_type), .stop_bits(stop_bits),
        .frame(frame), .frame_valid(frame_valid),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .fifo_count(fifo_count), .overflow(overflow), .ovf_clr(ovf_clr),
        .drop_cnt(drop_cnt)
    );

    always #5 clk_16bd = ~clk_16bd;

    // ---------------- reference model ----------------
    int m_len, m_par, m_typ, m_stop;
    int p_len, p_par, p_typ, p_stop;
    bit m_pend, m_err, m_busy, m_ovf, m_fvq;
    bit s1, s2, s3;
    int m_timer, m_drop;
    int q[$];

    task automatic model_step();
        bit fall, fvr, pop, full, legal, apply;
        int masked;
        if (rst) begin
            m_len = 8; m_par = 0; m_typ = 0; m_stop = 0;
            p_len = 8; p_par = 0; p_typ = 0; p_stop = 0;
            m_pend = 0; m_err = 0; m_busy = 0; m_ovf = 0; m_fvq = 0;
            s1 = 1; s2 = 1; s3 = 1; m_timer = 0; m_drop = 0;
            q.delete();
            return;
        end
        fall   = s3 && !s2;
        fvr    = frame_valid && !m_fvq;
        full   = (q.size() == DEPTH);
        pop    = (q.size() > 0) && rd_ready;
        masked = int'(frame) % (1 << m_len);
        if (pop) void'(q.pop_front());
        if (fvr) begin
            if (!full || pop) q.push_back(masked);
        end
        if (fvr && full && !pop) m_ovf = 1;
        else if (ovf_clr)        m_ovf = 0;

        apply = 0;
        if (!m_busy) begin
            if (fall) begin
                m_busy  = 1;
                m_timer = 16 * (2 + m_len + m_par + m_stop) + 16;
            end else if (m_pend) begin
                apply = 1;
            end
        end else begin
            if (fvr) m_busy = 0;
            else if (m_timer == 0) begin
                m_busy = 0;
                if (m_drop < 255) m_drop++;
            end else m_timer--;
        end
        if (apply) begin
            m_len = p_len; m_par = p_par; m_typ = p_typ; m_stop = p_stop;
            m_pend = 0;
        end
        legal = (cfg_frame_length >= 5) && (cfg_frame_length <= 9);
        m_err = cfg_wr && !legal;
        if (cfg_wr && legal) begin
            p_len = cfg_frame_length; p_par = cfg_parity;
            p_typ = cfg_parity_type;  p_stop = cfg_stop_bits;
            m_pend = 1;
        end
        s3 = s2; s2 = s1; s1 = rx;
        m_fvq = frame_valid;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("frame_length", 32'(frame_length), m_len);
        check("parity",       32'(parity),       m_par);
        check("parity_type",  32'(parity_type),  m_typ);
        check("stop_bits",    32'(stop_bits),    m_stop);
        check("cfg_pending",  32'(cfg_pending),  32'(m_pend));
        check("cfg_err",      32'(cfg_err),      32'(m_err));
        check("rd_valid",     32'(rd_valid),     32'(q.size() > 0));
        check("fifo_count",   32'(fifo_count),   q.size());
        check("overflow",     32'(overflow),     32'(m_ovf));
        check("drop_cnt",     32'(drop_cnt),     m_drop);
        if (q.size() > 0) check("rd_data", 32'(rd_data), q[0]);
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            model_step();
            @(posedge clk_16bd);
            #1;
            compare_all();
        end
    endtask

    task automatic do_reset();
        rst = 1; rx = 1; cfg_wr = 0; frame_valid = 0; rd_ready = 0; ovf_clr = 0;
        tick(2);
        rst = 0;
    endtask

    task automatic cfg_write(input int len, input bit p, input bit t, input bit s);
        cfg_wr = 1; cfg_frame_length = 4'(len);
        cfg_parity = p; cfg_parity_type = t; cfg_stop_bits = s;
        tick();
        cfg_wr = 0;
    endtask

    task automatic fv_pulse(input logic [8:0] f);
        frame_valid = 1; frame = f;
        tick();
        frame_valid = 0;
    endtask

    initial begin
        // reset state
        do_reset();
        check("rst_len", 32'(frame_length), 8);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_drop", 32'(drop_cnt), 0);

        // config applied on an idle line
        cfg_write(7, 1, 1, 0);
        check("cfgA_pending", 32'(cfg_pending), 1);
        tick();
        check("cfgA_pending_clr", 32'(cfg_pending), 0);
        check("cfgA_cfg", {28'd0, frame_length} << 3 | {29'd0, parity, parity_type, stop_bits}, (7 << 3) | 3'b110);

        // config held during a frame, applied after fv_rise
        do_reset();
        rx = 0;
        tick(4);
        cfg_write(5, 0, 0, 0);
        tick(3);
        check("busy_len_held", 32'(frame_length), 8);
        check("busy_pending", 32'(cfg_pending), 1);
        fv_pulse(9'h1FF);
        check("mask8_data", 32'(rd_data), 32'h0FF);
        check("len_still8", 32'(frame_length), 8);
        tick();
        check("len_applied5", 32'(frame_length), 5);
        rx = 1;
        tick(4);

        // timeout of a dropped frame at 8N1
        do_reset();
        rx = 0;
        tick(16);
        rx = 1;
        tick(154);
        check("drop_before", 32'(drop_cnt), 0);
        tick(30);
        check("drop_after", 32'(drop_cnt), 1);

        // overflow with frames 1..5, then drain
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            fv_pulse(9'(i));
            tick();
        end
        check("ovf_count", 32'(fifo_count), 4);
        check("ovf_flag", 32'(overflow), 1);
        rd_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_data", 32'(rd_data), i);
            tick();
        end
        rd_ready = 0;
        check("drain_empty", 32'(rd_valid), 0);
        ovf_clr = 1;
        tick();
        ovf_clr = 0;
        check("ovf_cleared", 32'(overflow), 0);

        // push into a full FIFO with a simultaneous pop
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            fv_pulse(9'(i));
            tick();
        end
        frame_valid = 1; frame = 9'd6; rd_ready = 1;
        tick();
        frame_valid = 0; rd_ready = 0;
        check("fullpop_count", 32'(fifo_count), 4);
        check("fullpop_ovf", 32'(overflow), 0);
        check("fullpop_head", 32'(rd_data), 2);
        rd_ready = 1;
        tick(4);
        rd_ready = 0;

        // rejected lengths
        do_reset();
        cfg_write(4, 1, 0, 1);
        check("err4", 32'(cfg_err), 1);
        check("err4_pend", 32'(cfg_pending), 0);
        tick();
        check("err4_clr", 32'(cfg_err), 0);
        cfg_write(10, 0, 1, 0);
        check("err10", 32'(cfg_err), 1);
        tick();
        check("err_len_kept", 32'(frame_length), 8);

        // random traffic against the model
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 24) == 0) rx = ~rx;
            cfg_wr           = ($urandom_range(0, 29) == 0);
            cfg_frame_length = 4'($urandom_range(3, 11));
            cfg_parity       = 1'($urandom);
            cfg_parity_type  = 1'($urandom);
            cfg_stop_bits    = 1'($urandom);
            frame_valid      = ($urandom_range(0, 3) == 0);
            frame            = 9'($urandom);
            rd_ready         = ($urandom_range(0, 2) == 0);
            ovf_clr          = ($urandom_range(0, 19) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Sits between the UART receive processor and downstream consumers, such as the VGA text/command path.
- Owns the receiver's frame configuration and drives it to the processor.
- Applies configuration changes only at frame boundaries.
- Tracks frame activity on the line and times out dropped frames.
- Buffers received frames in a small show-ahead FIFO behind a valid/ready read interface.

Parameters:
- DEPTH, 4, FIFO depth in frames; power of 2, ≥2.
- DEF_FRAME_LENGTH, 8, frame_length driven after reset.
- DEF_PARITY, 0, parity enable after reset.
- DEF_PARITY_TYPE, 0, parity type after reset (0 = even, 1 = odd).
- DEF_STOP_BITS, 0, stop bits after reset (0 = one, 1 = two).

Ports:
- clk_16bd  in  1  16x baud clock, the only clock.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  serial line, asynchronous; monitored only.
- cfg_wr  in  1  1-cycle strobe: load a pending configuration.
- cfg_frame_length  in  4  requested data bits; legal 5..9.
- cfg_parity  in  1  requested parity enable.
- cfg_parity_type  in  1  requested parity type.
- cfg_stop_bits  in  1  requested stop-bit count.
- cfg_pending  out  1  a configuration is loaded but not yet applied.
- cfg_err  out  1  1-cycle pulse: cfg_wr rejected.
- frame_length  out  4  active config to the processor.
- parity  out  1  active config to the processor.
- parity_type  out  1  active config to the processor.
- stop_bits  out  1  active config to the processor.
- frame  in  9  frame from the processor.
- frame_valid  in  1  frame-valid from the processor.
- rd_data  out  9  FIFO head.
- rd_valid  out  1  FIFO non-empty.
- rd_ready  in  1  consumer accepts the head.
- fifo_count  out  $clog2(DEPTH)+1  frames held.
- overflow  out  1  sticky: a frame was lost because the FIFO was full.
- ovf_clr  in  1  clears overflow.
- drop_cnt  out  8  saturating count of frames that timed out.

Behaviour:
- Reset, synchronous: active config = DEF_* values, cfg_pending = 0, cfg_err = 0, state IDLE.
  - FIFO empty: rd_valid = 0, fifo_count = 0; overflow = 0, drop_cnt = 0.
  - rx synchroniser flops = 1, frame_valid history = 0, timer = 0.
- Reset asserted mid-frame or mid-FIFO discards everything; the pending config is lost.
- rx goes through a 2-flop synchroniser. fall = previous synced 1 and current synced 0.
- fv_rise = frame_valid & ~frame_valid_q (frame_valid_q is frame_valid registered).
- Config write:
  - cfg_wr with cfg_frame_length in 5..9 loads the pending registers and sets cfg_pending; a second write overwrites the first.
  - Out-of-range cfg_wr pulses cfg_err on the next cycle; pending is unchanged.
- FSM, states IDLE and BUSY:
  - IDLE, fall: go to BUSY, load timer = 16*(2 + frame_length + parity + stop_bits) + 16 (8-bit, max 224).
  - IDLE, cfg_pending and no fall: copy pending to the active outputs, clear cfg_pending.
  - Fall takes priority: config is held until the next IDLE cycle.
  - A cfg_wr and an apply in the same cycle: the new write stays pending and is applied on a later cycle.
  - BUSY, fv_rise: go to IDLE.
  - BUSY, timer reaches 0 with no fv_rise: go to IDLE, drop_cnt += 1, saturating at 255.
  - BUSY otherwise: timer decrements. Active config never changes in BUSY.
- Capture:
  - fv_rise in any state pushes frame & ((1<<frame_length)-1), masked with the active config.
  - Push when full: frame discarded and overflow set, unless a pop occurs in the same cycle, in which case the push is accepted.
  - ovf_clr clears overflow; if a set occurs in the same cycle, the set wins.
- FIFO:
  - Show-ahead. rd_data is valid whenever rd_valid = 1; pop when rd_valid & rd_ready.
  - A push becomes visible at the head 1 cycle after fv_rise.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - Pop when empty is ignored.
  - rd_data is don't-care when rd_valid = 0.

Test Plan:
- Reset, then cfg_wr len=7, parity=1, type=1 with rx idle high → cfg_pending=1 for 1 cycle; outputs become 7/1/1/0 two cycles after the write.
- Drive rx low (start bit), then cfg_wr len=5 during the frame, frame_valid pulse with frame=9'h1FF → outputs stay at 8/0/0/0 until fv_rise; rd_data=9'h0FF (masked to 8 bits); len=5 applied on the next IDLE cycle.
- rx start bit with no frame_valid at 8N1 → BUSY lasts 176 cycles, then IDLE; drop_cnt=1.
- DEPTH=4, rd_ready=0, five frame_valid pulses with frames 1..5 → fifo_count=4, overflow=1; then rd_ready=1 → rd_data sequence 1,2,3,4.
- FIFO full, fv_rise in the same cycle as rd_ready=1 → new frame accepted, fifo_count stays 4, overflow stays 0.
- cfg_wr len=4, then len=10 → cfg_err pulses both times; cfg_pending=0; frame_length unchanged.
